mips_mem_dump_reader: RTL and testbench
=======================================

// Module: mips_mem_dump_reader
// PURPOSE
//   Post-halt readback engine for the pipelined MIPS32 data/instruction memory.
//   Once the core asserts HALTED, it reads a contiguous word range and streams
//   each word out over a valid/ready port with its address, for host/debug capture.
//   It is the reading end of program/data loading into Mem[] and replaces
//   hierarchical peeking at Mem[] for result checking.
// PARAMETERS
//   ADDR_W  10  memory word-address width; addresses wrap mod 2**ADDR_W
//   DATA_W  32  memory word width
//   CNT_W   11  width of word_count; max 2**CNT_W-1 words per dump
// PORTS
//   clk1         in   1       sole clock; all state updates on its rising edge
//   reset        in   1       synchronous, active-high
//   start        in   1       one-cycle request to begin a dump
//   base_addr    in   ADDR_W  first word address, sampled when start is accepted
//   word_count   in   CNT_W   number of words, sampled when start is accepted
//   halted       in   1       core HALTED flag; dump allowed only while 1
//   mem_rd_en    out  1       memory read strobe
//   mem_addr     out  ADDR_W  memory read address
//   mem_rd_data  in   DATA_W  read data, valid exactly 1 cycle after mem_rd_en
//   out_valid    out  1       stream beat valid
//   out_ready    in   1       sink ready
//   out_data     out  DATA_W  stream word
//   out_addr     out  ADDR_W  address of out_data
//   out_last     out  1       final beat of the dump
//   busy         out  1       high from start acceptance until return to IDLE
//   done         out  1       one-cycle pulse: dump completed
//   abort        out  1       one-cycle pulse: dump killed by halted falling
// BEHAVIOUR
//   - Reset: all outputs 0; FSM to IDLE; internal address/count/checksum cleared.
//   - FSM: IDLE -> READ -> CAPT -> SEND -> (READ | DONE) ; DONE -> IDLE.
//   - IDLE: start accepted only if halted=1; start with halted=0 is ignored.
//     Accepted start latches base_addr/word_count, busy=1 next cycle.
//     word_count=0: go straight to DONE, no memory reads, no beats.
//   - READ (1 cycle): mem_rd_en=1, mem_addr=current address.
//   - CAPT (1 cycle): latch mem_rd_data into out_data, out_addr=current addr.
//   - SEND: out_valid=1; out_data/out_addr/out_last stable until out_valid&out_ready.
//     On handshake: address+1 (wraps 2**ADDR_W-1 -> 0), remaining-1;
//     remaining hits 0 -> DONE else READ. Max throughput 1 word / 3 cycles.
//   - DONE (1 cycle): done=1, busy=0 next cycle in IDLE.
//   - start while busy: ignored. out_ready while out_valid=0: ignored.
//   - halted falling in any non-IDLE state: next cycle IDLE, out_valid=0,
//     busy=0, abort=1 for one cycle, done not asserted (beat may be withdrawn).
//   - reset mid-dump: overrides all, outputs 0 on the following edge.
//   - mem_rd_en is never asserted outside READ.
// CONFIGURATION
//   DUMP_CHECKSUM_EN defined: after the last data word one extra SEND beat,
//     out_data = XOR of all dumped words, out_addr = 0, out_last only on this
//     beat; word_count=0 still produces no beats. Checksum cleared on accept.
//   DUMP_CHECKSUM_EN undefined: no extra beat; out_last on last data word.
// TESTING
//   1 Mem[120]=85,Mem[121]=130, halted=1, start base=120 cnt=2, ready=1 ->
//     beats (120,85),(121,130,last); done pulse; mem_rd_en exactly 2 cycles.
//   2 factorial run Mem[198]=5040, base=198 cnt=3 with out_ready toggling 1/0
//     every cycle -> beats 198:5040,199:x,200:7 in order, data held while stalled.
//   3 start with halted=0 -> no busy, no mem_rd_en; cnt=0 with halted=1 ->
//     busy 1 cycle, done pulse, zero beats.
//   4 base=1023 cnt=2 -> out_addr 1023 then 0 (wrap).
//   5 halted dropped during 2nd beat of cnt=4 -> abort pulse, out_valid=0,
//     no done; reset mid-dump -> all outputs 0 next edge, later start works.
//   6 DUMP_CHECKSUM_EN, test 1 stimulus -> third beat data=215 (85^130),
//     addr 0, last; (121,130) beat has out_last=0.

Source files
------------

// File: rtl/mips_mem_dump_reader_if.sv
// mips_mem_dump_reader_if: start/status, memory read port and output stream of the dump reader
interface mips_mem_dump_reader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 11
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic              halted;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              abort;
  modport master (
    input  start, base_addr, word_count, halted, mem_rd_data, out_ready,
    output mem_rd_en, mem_addr, out_valid, out_data, out_addr, out_last, busy, done, abort
  );
  modport slave (
    output start, base_addr, word_count, halted, mem_rd_data, out_ready,
    input  mem_rd_en, mem_addr, out_valid, out_data, out_addr, out_last, busy, done, abort
  );
endinterface

// File: rtl/mips_mem_dump_reader.sv
// mips_mem_dump_reader: post-halt memory range readback streamed over valid/ready
// DUMP_CHECKSUM_EN adds a trailing XOR-checksum beat at address 0.
module mips_mem_dump_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 11
) (
  input logic clk1,
  input logic reset,
  mips_mem_dump_reader_if.master bus
);
`ifdef DUMP_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, READ, CAPT, SEND, DONE} state_t;
  state_t state, nxt;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  rem;
  logic [DATA_W-1:0] csum;
  logic              csum_beat;
  logic              abort_q;
  logic              hs, kill, fin, accept;
  assign hs     = bus.out_valid & bus.out_ready;
  assign kill   = (state == READ || state == CAPT || state == SEND) && !bus.halted;
  assign fin    = rem == CNT_W'(1);
  assign accept = state == IDLE && bus.start && bus.halted;
  assign bus.mem_rd_en = state == READ;
  assign bus.mem_addr  = addr;
  assign bus.out_valid = state == SEND;
  assign bus.busy      = state != IDLE;
  assign bus.done      = state == DONE;
  assign bus.abort     = abort_q;
  always_ff @(posedge clk1)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = accept ? (bus.word_count == '0 ? DONE : READ) : IDLE;
      READ: nxt = CAPT;
      CAPT: nxt = SEND;
      SEND: nxt = !hs ? SEND : (csum_beat || (fin && !CK)) ? DONE : fin ? SEND : READ;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (kill) nxt = IDLE;
  end
  always_ff @(posedge clk1) begin
    if (reset) begin
      addr         <= '0;
      rem          <= '0;
      csum         <= '0;
      csum_beat    <= 1'b0;
      abort_q      <= 1'b0;
      bus.out_data <= '0;
      bus.out_addr <= '0;
      bus.out_last <= 1'b0;
    end else begin
      abort_q <= kill;
      if (accept) begin
        addr      <= bus.base_addr;
        rem       <= bus.word_count;
        csum      <= '0;
        csum_beat <= 1'b0;
      end
      if (state == CAPT) begin
        bus.out_data <= bus.mem_rd_data;
        bus.out_addr <= addr;
        bus.out_last <= fin && !CK;
      end
      // the last data handshake turns the held beat into the checksum beat
      if (state == SEND && hs && !csum_beat) begin
        addr <= addr + 1'b1;
        rem  <= rem - 1'b1;
        csum <= csum ^ bus.out_data;
        if (CK && fin) begin
          bus.out_data <= csum ^ bus.out_data;
          bus.out_addr <= '0;
          bus.out_last <= 1'b1;
          csum_beat    <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mips_mem_dump_reader.sv
// tb_mips_mem_dump_reader: randomized dumps checked by a queue scoreboard against a memory model
module tb_mips_mem_dump_reader;
  localparam int AW = 10, DW = 32, CW = 11;
`ifdef DUMP_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  typedef struct packed {logic [DW-1:0] d; logic [AW-1:0] a; logic l;} beat_t;
  logic clk1 = 1'b0, reset = 1'b1;
  always #5 clk1 = ~clk1;
  mips_mem_dump_reader_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus();
  mips_mem_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (.clk1(clk1), .reset(reset), .bus(bus));
  beat_t q[$];
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int checks = 0, errors = 0, rd_cnt = 0, done_cnt = 0, busy_cnt = 0, mode = 0;
  bit hold = 1'b0;
  beat_t held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk1);
    #1;
  endtask

  always @(posedge clk1) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];

  always @(posedge clk1) begin
    #1;
    bus.out_ready = mode == 0 ? 1'b1 : mode == 1 ? ~bus.out_ready :
                    mode == 2 ? ($urandom_range(0, 1) != 0) : 1'b0;
  end

  always @(negedge clk1) begin
    beat_t cur;
    if (bus.mem_rd_en) rd_cnt++;
    if (bus.done) done_cnt++;
    if (bus.busy) busy_cnt++;
    cur = {bus.out_data, bus.out_addr, bus.out_last};
    if (bus.out_valid) begin
      if (hold) chk("hold_stable", cur, held);
      if (bus.out_ready) begin
        if (q.size() == 0) chk("unexpected_beat", {1'b1, cur}, {1'b0, cur});
        else chk("beat", cur, q.pop_front());
        hold = 1'b0;
      end else begin
        hold = 1'b1;
        held = cur;
      end
    end else hold = 1'b0;
  end

  task automatic expect_dump(input int base, input int cnt);
    logic [DW-1:0] cs = '0;
    for (int i = 0; i < cnt; i++) begin
      logic [AW-1:0] a = AW'(base + i);
      q.push_back({mem[a], a, (i == cnt - 1) && !CK});
      cs ^= mem[a];
    end
    if (CK && cnt > 0) q.push_back({cs, {AW{1'b0}}, 1'b1});
  endtask

  task automatic pulse_start(input int base, input int cnt);
    bus.start = 1'b1;
    bus.base_addr = AW'(base);
    bus.word_count = CW'(cnt);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic run_dump(input int base, input int cnt, input int m);
    int r0 = rd_cnt, d0 = done_cnt, b0 = busy_cnt, n = 0;
    expect_dump(base, cnt);
    mode = m;
    pulse_start(base, cnt);
    while (done_cnt == d0 && n < 2000) begin
      @(posedge clk1);
      n++;
    end
    #1;
    chk("done_in_time", n < 2000, 1);
    chk("queue_drained", q.size(), 0);
    chk("rd_en_cycles", rd_cnt - r0, cnt);
    if (cnt == 0) chk("busy_cycles", busy_cnt - b0, 1);
    tick();
    chk("done_once", done_cnt - d0, 1);
    chk("idle_after", {bus.busy, bus.out_valid}, 0);
    q.delete();
  endtask

  initial begin
    int n, r0, b0;
    bus.start = 1'b0; bus.base_addr = '0; bus.word_count = '0;
    bus.halted = 1'b1; bus.out_ready = 1'b1; bus.mem_rd_data = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    tick(3);
    chk("reset_ctrl", {bus.busy, bus.out_valid, bus.mem_rd_en, bus.done, bus.abort, bus.out_last}, 0);
    chk("reset_data", {bus.out_data, bus.out_addr}, 0);
    reset = 1'b0;
    tick();
    mem[120] = 85; mem[121] = 130;
    run_dump(120, 2, 0);
    mem[198] = 5040; mem[200] = 7;
    run_dump(198, 3, 1);
    bus.halted = 1'b0;
    r0 = rd_cnt; b0 = busy_cnt;
    pulse_start(10, 3);
    tick(5);
    chk("not_halted_busy", busy_cnt - b0, 0);
    chk("not_halted_rd", rd_cnt - r0, 0);
    bus.halted = 1'b1;
    run_dump(55, 0, 0);
    run_dump(1023, 2, 2);
    for (int k = 0; k < 10; k++)
      run_dump($urandom_range(0, (1 << AW) - 1), $urandom_range(1, 6), $urandom_range(0, 2));
    mode = 0;
    expect_dump(300, 4);
    pulse_start(300, 4);
    n = 0;
    while (q.size() > (CK ? 4 : 3) && n < 200) begin
      @(posedge clk1);
      n++;
    end
    mode = 3;
    #1;
    chk("abort_first_beat", n < 200, 1);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("abort_second_presented", bus.out_valid, 1);
    chk("abort_second_addr", bus.out_addr, 301);
    bus.halted = 1'b0;
    tick();
    chk("abort_pulse", {bus.abort, bus.out_valid, bus.busy, bus.done}, 4'b1000);
    tick();
    chk("abort_cleared", bus.abort, 0);
    bus.halted = 1'b1;
    q.delete();
    mode = 0;
    expect_dump(400, 5);
    pulse_start(400, 5);
    tick(4);
    reset = 1'b1;
    tick();
    chk("midreset_ctrl", {bus.busy, bus.out_valid, bus.mem_rd_en, bus.done, bus.abort, bus.out_last}, 0);
    chk("midreset_data", {bus.out_data, bus.out_addr}, 0);
    reset = 1'b0;
    q.delete();
    tick();
    run_dump($urandom_range(0, (1 << AW) - 1), $urandom_range(1, 6), 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
